uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 100000: clock cycles to wait for i_tx_done before abort, legal minimum 16.
REQ-003 SHALL have port i_clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_n_reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester send request, level, held until o_grant.
REQ-006 SHALL have port i_data  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 SHALL have port o_grant  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester k accepted.
REQ-008 SHALL have port o_done  output  NUM_REQ  one-hot, one-cycle pulse: requester k's byte fully transmitted.
REQ-009 SHALL have port o_timeout  output  1  one-cycle pulse: transmission aborted by watchdog.
REQ-010 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port o_tx_request  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 SHALL have port o_tx_data  output  8  byte to the UART transmitter.
REQ-013 SHALL have port i_tx_busy  input  1  transmitter busy status.
REQ-014 SHALL have port i_tx_done  input  1  transmitter one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT_DONE; all outputs registered.
REQ-016 SHALL, in IDLE with any i_req bit high and i_tx_busy low, select a winner round-robin, searching upward (wrapping) from pointer+1, and enter LAUNCH on the next edge.
REQ-017 SHALL, in IDLE with i_tx_busy high, stay in IDLE and grant nothing.
REQ-018 SHALL, on the IDLE->LAUNCH edge, capture the winner's byte into o_tx_data and the winner's index into owner.
REQ-019 SHALL assert o_grant[owner] and o_tx_request together for exactly the LAUNCH cycle, then enter WAIT_DONE.
REQ-020 SHALL hold o_tx_data stable from LAUNCH until the next grant.
REQ-021 SHALL, in WAIT_DONE on i_tx_done high, pulse o_done[owner] for one cycle, set pointer to owner, and return to IDLE.
REQ-022 SHALL count cycles in WAIT_DONE, reset to 0 on LAUNCH entry; if TIMEOUT is reached without i_tx_done, pulse o_timeout (no o_done), set pointer to owner, and return to IDLE.
REQ-023 SHALL, when i_tx_done and timeout expiry coincide, treat the event as done (o_done, no o_timeout).
REQ-024 SHALL ignore i_req changes outside IDLE; a requester dropping i_req before grant is withdrawn without side effects.
REQ-025 SHALL ignore i_tx_done outside WAIT_DONE.
REQ-026 SHALL allow at most one grant per LAUNCH; minimum spacing between consecutive grants is 3 cycles (LAUNCH, >=1 WAIT_DONE, IDLE).
REQ-027 SHALL give pointer wrap-around: after NUM_REQ-1 the search continues at 0.

Reset
REQ-028 SHALL, while i_n_reset is low, force state IDLE, pointer NUM_REQ-1 (so requester 0 wins first), owner 0, counter 0.
REQ-029 SHALL reset o_grant, o_done, o_timeout, o_busy, o_tx_request to 0 and o_tx_data to 8'h00.
REQ-030 SHALL, on reset mid-transfer, abandon the byte with no o_done or o_timeout pulse after release.

Verification
REQ-031 Single: i_req=4'b0100, data2=8'h41 -> o_grant=4'b0100 and o_tx_request one cycle, o_tx_data=8'h41; i_tx_done 10 cycles later -> o_done=4'b0100 next cycle, o_busy low.
REQ-032 Fairness: i_req=4'b1111 held after reset, i_tx_done 5 cycles after each launch -> grant order 0,1,2,3,0; no requester granted twice before all four.
REQ-033 Wrap: pointer=3, i_req=4'b1001 -> requester 0 granted, then requester 3.
REQ-034 Timeout: TIMEOUT=16, grant requester 1, never pulse i_tx_done -> o_timeout one cycle 16 cycles after LAUNCH, o_done stays 0, next grant goes to requester 2 if requesting.
REQ-035 Busy gate: i_tx_busy=1 in IDLE with i_req=4'b0001 -> no grant until i_tx_busy falls, grant the cycle after.
REQ-036 Reset mid-operation: i_n_reset low during WAIT_DONE -> all outputs 0 immediately; after release, i_req=4'b0001 -> requester 0 granted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Request/grant bus between requesters, the arbiter and the UART transmitter.
// Signal names keep the arbiter's point of view (i_* into it, o_* out of it).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_data;
    logic [NUM_REQ-1:0]   o_grant;
    logic [NUM_REQ-1:0]   o_done;
    logic                 o_timeout;
    logic                 o_busy;
    logic                 o_tx_request;
    logic [7:0]           o_tx_data;
    logic                 i_tx_busy;
    logic                 i_tx_done;

    // Requesters and transmitter side
    modport master (
        output i_req, i_data, i_tx_busy, i_tx_done,
        input  o_grant, o_done, o_timeout, o_busy, o_tx_request, o_tx_data
    );

    // Arbiter side
    modport slave (
        input  i_req, i_data, i_tx_busy, i_tx_done,
        output o_grant, o_done, o_timeout, o_busy, o_tx_request, o_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// One byte in flight at a time; a watchdog aborts a frame that never completes.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic               i_clock,
    input  logic               i_n_reset,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                timeout_q;
    logic                busy_q;
    logic                tx_request_q;
    logic [7:0]          tx_data_q;

    logic                any_req_d;
    logic [IDX_W-1:0]    winner_d;
    int                  best_d;
    int                  dist_d;
    logic [7:0]          req_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_byte[g] = bus.i_data[8*g +: 8];
    end

    // Round-robin search: requester ptr+1 is closest, ptr itself is farthest
    always_comb begin
        any_req_d = 1'b0;
        winner_d  = '0;
        best_d    = NUM_REQ + 1;
        dist_d    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            dist_d = (k > int'(ptr_q)) ? (k - int'(ptr_q)) : (k - int'(ptr_q) + NUM_REQ);
            if (bus.i_req[k] && (dist_d < best_d)) begin
                best_d    = dist_d;
                winner_d  = IDX_W'(k);
                any_req_d = 1'b1;
            end
        end
    end

    // Control FSM with registered outputs; pulse outputs default low each cycle
    always_ff @(posedge i_clock or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q      <= IDLE;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            tx_request_q <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            grant_q      <= '0;
            done_q       <= '0;
            timeout_q    <= 1'b0;
            tx_request_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d && !bus.i_tx_busy) begin
                        state_q      <= LAUNCH;
                        owner_q      <= winner_d;
                        tx_data_q    <= req_byte[winner_d];
                        grant_q      <= ONE_HOT0 << winner_d;
                        tx_request_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                    end
                end
                LAUNCH: begin
                    // cnt_q tracks cycles elapsed since the LAUNCH cycle
                    state_q <= WAIT_DONE;
                    cnt_q   <= CNT_W'(1);
                end
                WAIT_DONE: begin
                    // A done pulse wins over a watchdog expiry in the same cycle
                    if (bus.i_tx_done) begin
                        done_q  <= ONE_HOT0 << owner_q;
                        ptr_q   <= owner_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        ptr_q     <= owner_q;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_grant      = grant_q;
    assign bus.o_done       = done_q;
    assign bus.o_timeout    = timeout_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_tx_request = tx_request_q;
    assign bus.o_tx_data    = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 requesters, 16-cycle watchdog.
module tb_uart_tx_arbiter;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic seen;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .i_clock   (clk),
        .i_n_reset (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step until a grant appears (bounded), then check it and the launch pulse
    task automatic expect_grant(input string tag, input logic [3:0] exp_grant, input logic [7:0] exp_data);
        for (int n = 0; n < 20 && bus.o_grant == 4'b0000; n++) tick();
        chk({tag, "_grant"}, 32'(bus.o_grant), 32'(exp_grant));
        chk({tag, "_txreq"}, 32'(bus.o_tx_request), 32'(1'b1));
        chk({tag, "_txdata"}, 32'(bus.o_tx_data), 32'(exp_data));
    endtask

    // From the LAUNCH cycle, pulse i_tx_done d cycles later and check completion
    task automatic serve(input string tag, input int d, input logic [3:0] exp_done);
        repeat (d) tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk({tag, "_done"}, 32'(bus.o_done), 32'(exp_done));
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'(1'b0));
        chk({tag, "_tmo"}, 32'(bus.o_timeout), 32'(1'b0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        seen  = 1'b0;
        rst_n = 1'b0;
        bus.i_req     = 4'b0000;
        bus.i_data    = {8'h44, 8'h41, 8'h22, 8'h11};
        bus.i_tx_busy = 1'b0;
        bus.i_tx_done = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(bus.o_grant), 32'h0);
        chk("rst_done", 32'(bus.o_done), 32'h0);
        chk("rst_tmo", 32'(bus.o_timeout), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_txreq", 32'(bus.o_tx_request), 32'h0);
        chk("rst_txdata", 32'(bus.o_tx_data), 32'h0);
        rst_n = 1'b1;

        // Single requester 2
        bus.i_req = 4'b0100;
        expect_grant("single", 4'b0100, 8'h41);
        chk("single_busy", 32'(bus.o_busy), 32'h1);
        bus.i_req = 4'b0000;
        tick();
        chk("single_grant_pulse", 32'(bus.o_grant), 32'h0);
        chk("single_txreq_pulse", 32'(bus.o_tx_request), 32'h0);
        chk("single_hold", 32'(bus.o_tx_data), 32'h41);
        serve("single", 9, 4'b0100);
        chk("single_hold2", 32'(bus.o_tx_data), 32'h41);
        tick();
        chk("single_done_pulse", 32'(bus.o_done), 32'h0);

        // Fairness with all four requesting
        do_reset();
        bus.i_req = 4'b1111;
        expect_grant("fair0", 4'b0001, 8'h11);
        serve("fair0", 5, 4'b0001);
        expect_grant("fair1", 4'b0010, 8'h22);
        serve("fair1", 5, 4'b0010);
        expect_grant("fair2", 4'b0100, 8'h41);
        serve("fair2", 5, 4'b0100);
        expect_grant("fair3", 4'b1000, 8'h44);
        serve("fair3", 5, 4'b1000);
        expect_grant("fair4", 4'b0001, 8'h11);
        serve("fair4", 5, 4'b0001);

        // Wrap-around from pointer 3
        do_reset();
        bus.i_req = 4'b1001;
        expect_grant("wrap0", 4'b0001, 8'h11);
        serve("wrap0", 3, 4'b0001);
        expect_grant("wrap3", 4'b1000, 8'h44);
        serve("wrap3", 3, 4'b1000);
        expect_grant("wrap0b", 4'b0001, 8'h11);
        bus.i_req = 4'b0000;
        serve("wrap0b", 3, 4'b0001);

        // Watchdog timeout on requester 1, then requester 2 is next
        do_reset();
        bus.i_req = 4'b0010;
        expect_grant("tmo", 4'b0010, 8'h22);
        bus.i_req = 4'b0110;
        repeat (15) tick();
        chk("tmo_early", 32'(bus.o_timeout), 32'h0);
        chk("tmo_early_busy", 32'(bus.o_busy), 32'h1);
        tick();
        chk("tmo_pulse", 32'(bus.o_timeout), 32'h1);
        chk("tmo_no_done", 32'(bus.o_done), 32'h0);
        chk("tmo_busy", 32'(bus.o_busy), 32'h0);
        tick();
        chk("tmo_pulse_end", 32'(bus.o_timeout), 32'h0);
        chk("tmo_next", 32'(bus.o_grant), 32'(4'b0100));
        bus.i_req = 4'b0000;
        // i_tx_done coinciding with expiry counts as done
        serve("coincide", 15, 4'b0100);

        // i_tx_done in IDLE is ignored
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        chk("idle_done_ignored", 32'(bus.o_done), 32'h0);

        // Transmitter busy gates the grant
        bus.i_tx_busy = 1'b1;
        bus.i_req     = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("busy_gate", 32'(bus.o_grant), 32'h0);
        end
        bus.i_tx_busy = 1'b0;
        tick();
        chk("busy_release", 32'(bus.o_grant), 32'(4'b0001));
        bus.i_req = 4'b0000;
        serve("busy", 4, 4'b0001);

        // Reset in the middle of WAIT_DONE
        bus.i_req = 4'b0100;
        expect_grant("mid", 4'b0100, 8'h41);
        bus.i_req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_grant", 32'(bus.o_grant), 32'h0);
        chk("mid_done", 32'(bus.o_done), 32'h0);
        chk("mid_tmo", 32'(bus.o_timeout), 32'h0);
        chk("mid_busy", 32'(bus.o_busy), 32'h0);
        chk("mid_txreq", 32'(bus.o_tx_request), 32'h0);
        chk("mid_txdata", 32'(bus.o_tx_data), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            seen = seen | bus.o_timeout | bus.o_busy | (|bus.o_done);
        end
        chk("mid_abandoned", 32'(seen), 32'h0);
        bus.i_req = 4'b0001;
        expect_grant("mid_after", 4'b0001, 8'h11);
        bus.i_req = 4'b0000;
        serve("mid_after", 2, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
